clock_tap_tracker: RTL and testbench

CLOCK_TAP_TRACKER -- requirements
Module: clock_tap_tracker

---
 rtl/clock_tap_tracker.sv | 183 ++++++++++++++++++
 tb/tb_clock_tap_tracker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/clock_tap_tracker.sv
// rtl/clock_tap_tracker.sv - averages phase-difference samples and steps a delay tap toward TARGET.
// Optional manual tap stepping via btn_up/btn_down is enabled by defining CLOCK_TAP_MANUAL_EN.
module clock_tap_tracker #(
  parameter int TAP_INITIAL    = 50,
  parameter int TAP_MAX        = 499,
  parameter int TARGET         = 0,
  parameter int DEADBAND       = 2,
  parameter int AVG_LOG2       = 3,
  parameter int SETTLE_SAMPLES = 4,
  parameter int LOCK_COUNT     = 4
) (
  input  logic               eclk,
  input  logic               ereset,
  input  logic signed [15:0] diffticks,
  input  logic               diff_valid,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [8:0]         clock_tap,
  output logic               locked,
  output logic               tap_changed
);

  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int SW    = (SETTLE_SAMPLES < 1) ? 1 : $clog2(SETTLE_SAMPLES + 1);
  localparam int LW    = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE_SAMPLES - 1);
  localparam logic [LW-1:0]     LOCK_T      = LW'(LOCK_COUNT);
  localparam logic [8:0]        TAP_MAX_T   = 9'(TAP_MAX);
  localparam logic [8:0]        TAP_INIT_T  = 9'(TAP_INITIAL);
  localparam logic signed [17:0] TARGET_T   = 18'(TARGET);
  localparam logic signed [17:0] DB_T       = 18'(DEADBAND);
  localparam logic signed [17:0] NEG_DB_T   = 18'(-DEADBAND);

  typedef enum logic [1:0] {S_INIT, S_ACCUM, S_DECIDE, S_SETTLE} state_t;
  localparam state_t S_AFTER_CHANGE = (SETTLE_SAMPLES == 0) ? S_ACCUM : S_SETTLE;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]            settle_q, settle_d;
  logic [LW-1:0]            lock_q, lock_d;
  logic                     locked_q, locked_d;
  logic [8:0]               tap_q, tap_d;
  logic                     changed_q, changed_d;

  logic signed [17:0] avg18, err;
  logic               want_up, want_down, auto_inc, auto_dec, auto_move;
  logic               cnt_last, settle_last;
  logic               man_step, man_up;

  // avg always fits 16 bits, so the cast to 18 bits only drops sign copies
  assign avg18      = 18'(acc_q >>> AVG_LOG2);
  assign err        = avg18 - TARGET_T;
  assign want_up    = err > DB_T;
  assign want_down  = err < NEG_DB_T;
  assign auto_inc   = want_up && (tap_q != TAP_MAX_T);
  assign auto_dec   = want_down && (tap_q != 9'd0);
  assign auto_move  = auto_inc || auto_dec;
  assign cnt_last   = (cnt_q == CNT_LAST);
  assign settle_last = (settle_q == SETTLE_LAST);

`ifdef CLOCK_TAP_MANUAL_EN
  assign man_step = (btn_up ^ btn_down) && (state_q != S_INIT);
  assign man_up   = btn_up;
`else
  logic unused_btn;
  assign unused_btn = btn_up | btn_down;
  assign man_step   = 1'b0;
  assign man_up     = 1'b0;
`endif

  always_ff @(posedge eclk) begin
    if (ereset) begin
      state_q   <= S_INIT;
      acc_q     <= '0;
      cnt_q     <= '0;
      settle_q  <= '0;
      lock_q    <= '0;
      locked_q  <= 1'b0;
      tap_q     <= TAP_INIT_T;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      lock_q    <= lock_d;
      locked_q  <= locked_d;
      tap_q     <= tap_d;
      changed_q <= changed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_ACCUM;
      S_ACCUM:  if (diff_valid && cnt_last) state_d = S_DECIDE;
      S_DECIDE: state_d = auto_move ? S_AFTER_CHANGE : S_ACCUM;
      S_SETTLE: if (diff_valid && settle_last) state_d = S_ACCUM;
      default:  state_d = S_INIT;
    endcase
    if (man_step) state_d = S_AFTER_CHANGE;
  end

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    lock_d    = lock_q;
    locked_d  = locked_q;
    tap_d     = tap_q;
    changed_d = 1'b0;
    case (state_q)
      S_INIT: begin
        acc_d = '0;
        cnt_d = '0;
      end
      S_ACCUM: begin
        if (diff_valid) begin
          acc_d = acc_q + ACC_W'(diffticks);
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECIDE: begin
        acc_d    = '0;
        cnt_d    = '0;
        settle_d = '0;
        if (auto_inc || auto_dec) begin
          tap_d     = auto_inc ? tap_q + 9'd1 : tap_q - 9'd1;
          changed_d = 1'b1;
          lock_d    = '0;
          locked_d  = 1'b0;
        end else if (want_up || want_down) begin
          lock_d   = '0;
          locked_d = 1'b0;
        end else begin
          if (lock_q != LOCK_T) lock_d = lock_q + LW'(1);
          locked_d = (lock_d == LOCK_T);
        end
      end
      S_SETTLE: begin
        if (diff_valid) begin
          if (settle_last) begin
            settle_d = '0;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            settle_d = settle_q + SW'(1);
          end
        end
      end
      default: ;
    endcase
    // a manual step overrides whatever the automatic path decided this cycle
    if (man_step) begin
      acc_d     = '0;
      cnt_d     = '0;
      settle_d  = '0;
      lock_d    = '0;
      locked_d  = 1'b0;
      tap_d     = tap_q;
      changed_d = 1'b0;
      if (man_up && tap_q != TAP_MAX_T) begin
        tap_d     = tap_q + 9'd1;
        changed_d = 1'b1;
      end else if (!man_up && tap_q != 9'd0) begin
        tap_d     = tap_q - 9'd1;
        changed_d = 1'b1;
      end
    end
  end

  always_comb begin
    clock_tap   = tap_q;
    locked      = locked_q;
    tap_changed = changed_q;
  end

endmodule

// File: tb/tb_clock_tap_tracker.sv
// tb/tb_clock_tap_tracker.sv - directed self-checking bench for clock_tap_tracker.
module tb_clock_tap_tracker;

  logic eclk = 1'b0;
  always #5 eclk = ~eclk;

  logic               ereset, diff_valid, btn_up, btn_down;
  logic signed [15:0] diffticks, diff_neg;
  logic [8:0]         tap_m, tap_h, tap_l;
  logic               locked_m, locked_h, locked_l;
  logic               chg_m, chg_h, chg_l;

  assign diff_neg = -diffticks;

`ifdef CLOCK_TAP_MANUAL_EN
  localparam bit MAN = 1'b1;
`else
  localparam bit MAN = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  clock_tap_tracker #(.TAP_INITIAL(50), .TAP_MAX(499), .TARGET(0), .DEADBAND(2), .AVG_LOG2(2),
                      .SETTLE_SAMPLES(2), .LOCK_COUNT(3)) u_main (
    .eclk(eclk), .ereset(ereset), .diffticks(diffticks), .diff_valid(diff_valid),
    .btn_up(btn_up), .btn_down(btn_down), .clock_tap(tap_m), .locked(locked_m), .tap_changed(chg_m));

  clock_tap_tracker #(.TAP_INITIAL(499), .TAP_MAX(499), .TARGET(0), .DEADBAND(2), .AVG_LOG2(2),
                      .SETTLE_SAMPLES(2), .LOCK_COUNT(3)) u_hi (
    .eclk(eclk), .ereset(ereset), .diffticks(diffticks), .diff_valid(diff_valid),
    .btn_up(btn_up), .btn_down(btn_down), .clock_tap(tap_h), .locked(locked_h), .tap_changed(chg_h));

  clock_tap_tracker #(.TAP_INITIAL(0), .TAP_MAX(499), .TARGET(0), .DEADBAND(2), .AVG_LOG2(2),
                      .SETTLE_SAMPLES(2), .LOCK_COUNT(3)) u_lo (
    .eclk(eclk), .ereset(ereset), .diffticks(diff_neg), .diff_valid(diff_valid),
    .btn_up(btn_up), .btn_down(btn_down), .clock_tap(tap_l), .locked(locked_l), .tap_changed(chg_l));

  task automatic tick();
    @(posedge eclk);
    #1;
  endtask

  task automatic strobe(input int v);
    diffticks  = 16'(v);
    diff_valid = 1'b1;
    tick();
    diff_valid = 1'b0;
  endtask

  // four strobes, then the DECIDE cycle; returns in the cycle the decision is visible
  task automatic batch(input int v);
    repeat (4) strobe(v);
    tick();
  endtask

  task automatic do_reset();
    ereset = 1'b1;
    tick();
    tick();
    ereset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    ereset = 1'b1; diff_valid = 1'b1; diffticks = 16'sd100; btn_up = 1'b1;
    tick();
    if (tap_m !== 9'd50) begin bad++; $display("FAIL reset_tap got=%0d want=50", tap_m); end total++;
    if (locked_m !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0b want=0", locked_m); end total++;
    if (chg_m !== 1'b0) begin bad++; $display("FAIL reset_changed got=%0b want=0", chg_m); end total++;
    if (tap_h !== 9'd499) begin bad++; $display("FAIL reset_tap_hi got=%0d want=499", tap_h); end total++;
    if (tap_l !== 9'd0) begin bad++; $display("FAIL reset_tap_lo got=%0d want=0", tap_l); end total++;
    diff_valid = 1'b0; btn_up = 1'b0;
    tick();
    ereset = 1'b0;
    tick();
  endtask

  task automatic test_up();
    do_reset();
    repeat (4) strobe(5);
    if (tap_m !== 9'd50) begin bad++; $display("FAIL up_early_tap got=%0d want=50", tap_m); end total++;
    tick();
    if (tap_m !== 9'd51) begin bad++; $display("FAIL up_tap got=%0d want=51", tap_m); end total++;
    if (chg_m !== 1'b1) begin bad++; $display("FAIL up_pulse got=%0b want=1", chg_m); end total++;
    tick();
    if (chg_m !== 1'b0) begin bad++; $display("FAIL up_pulse_end got=%0b want=0", chg_m); end total++;
  endtask

  task automatic test_down();
    do_reset();
    strobe(-6); strobe(-6); strobe(-6); strobe(-7);
    tick();
    if (tap_m !== 9'd49) begin bad++; $display("FAIL down_tap got=%0d want=49", tap_m); end total++;
    if (chg_m !== 1'b1) begin bad++; $display("FAIL down_pulse got=%0b want=1", chg_m); end total++;
    strobe(20);
    if (tap_m !== 9'd49 || chg_m !== 1'b0) begin bad++; $display("FAIL settle1 got=%0d/%0b want=49/0", tap_m, chg_m); end total++;
    strobe(20);
    if (tap_m !== 9'd49 || chg_m !== 1'b0) begin bad++; $display("FAIL settle2 got=%0d/%0b want=49/0", tap_m, chg_m); end total++;
    batch(0);
    if (tap_m !== 9'd49 || chg_m !== 1'b0) begin bad++; $display("FAIL settle_ignored got=%0d/%0b want=49/0", tap_m, chg_m); end total++;
  endtask

  task automatic test_lock();
    do_reset();
    batch(1);
    if (locked_m !== 1'b0) begin bad++; $display("FAIL lock_d1 got=%0b want=0", locked_m); end total++;
    batch(1);
    if (locked_m !== 1'b0) begin bad++; $display("FAIL lock_d2 got=%0b want=0", locked_m); end total++;
    batch(1);
    if (locked_m !== 1'b1) begin bad++; $display("FAIL lock_d3 got=%0b want=1", locked_m); end total++;
    if (tap_m !== 9'd50) begin bad++; $display("FAIL lock_tap got=%0d want=50", tap_m); end total++;
    strobe(9); strobe(9);
    if (locked_m !== 1'b1) begin bad++; $display("FAIL lock_hold got=%0b want=1", locked_m); end total++;
    strobe(9); strobe(9);
    tick();
    if (locked_m !== 1'b0) begin bad++; $display("FAIL unlock got=%0b want=0", locked_m); end total++;
    if (tap_m !== 9'd51 || chg_m !== 1'b1) begin bad++; $display("FAIL unlock_tap got=%0d/%0b want=51/1", tap_m, chg_m); end total++;
  endtask

  task automatic test_saturate();
    do_reset();
    batch(0); batch(0); batch(0);
    if (locked_h !== 1'b1) begin bad++; $display("FAIL sat_prelock got=%0b want=1", locked_h); end total++;
    batch(5);
    if (tap_h !== 9'd499) begin bad++; $display("FAIL sat_hi_tap got=%0d want=499", tap_h); end total++;
    if (chg_h !== 1'b0) begin bad++; $display("FAIL sat_hi_pulse got=%0b want=0", chg_h); end total++;
    if (locked_h !== 1'b0) begin bad++; $display("FAIL sat_hi_locked got=%0b want=0", locked_h); end total++;
    if (tap_l !== 9'd0) begin bad++; $display("FAIL sat_lo_tap got=%0d want=0", tap_l); end total++;
    if (chg_l !== 1'b0 || locked_l !== 1'b0) begin bad++; $display("FAIL sat_lo_flags got=%0b/%0b want=0/0", chg_l, locked_l); end total++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    batch(5);
    strobe(0); strobe(0);
    strobe(5); strobe(5);
    ereset = 1'b1; diffticks = 16'sd5; diff_valid = 1'b1;
    tick();
    diff_valid = 1'b0;
    if (tap_m !== 9'd50 || locked_m !== 1'b0) begin bad++; $display("FAIL midreset got=%0d/%0b want=50/0", tap_m, locked_m); end total++;
    ereset = 1'b0;
    tick();
    strobe(5); strobe(5);
    tick(); tick();
    if (tap_m !== 9'd50 || chg_m !== 1'b0) begin bad++; $display("FAIL midreset_half got=%0d/%0b want=50/0", tap_m, chg_m); end total++;
    strobe(5); strobe(5);
    tick();
    if (tap_m !== 9'd51 || chg_m !== 1'b1) begin bad++; $display("FAIL midreset_full got=%0d/%0b want=51/1", tap_m, chg_m); end total++;
  endtask

  task automatic test_manual();
    int exp_tap;
    do_reset();
    repeat (4) strobe(-5);
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    exp_tap = MAN ? 51 : 49;
    if (tap_m !== 9'(exp_tap) || chg_m !== 1'b1) begin bad++; $display("FAIL man_override got=%0d/%0b want=%0d/1", tap_m, chg_m, exp_tap); end total++;
    tick(); tick();
    btn_up = 1'b1; btn_down = 1'b1;
    tick();
    btn_up = 1'b0; btn_down = 1'b0;
    if (tap_m !== 9'(exp_tap) || chg_m !== 1'b0) begin bad++; $display("FAIL man_both got=%0d/%0b want=%0d/0", tap_m, chg_m, exp_tap); end total++;
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    if (MAN) exp_tap = exp_tap + 1;
    if (tap_m !== 9'(exp_tap) || chg_m !== MAN) begin bad++; $display("FAIL man_up got=%0d/%0b want=%0d/%0b", tap_m, chg_m, exp_tap, MAN); end total++;
  endtask

  initial begin
    ereset = 1'b1; diff_valid = 1'b0; diffticks = '0; btn_up = 1'b0; btn_down = 1'b0;
    test_reset();
    test_up();
    test_down();
    test_lock();
    test_saturate();
    test_reset_mid();
    test_manual();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
